// File: rtl/hack_memory_map_pkg.sv
// Shared types and helpers for the Hack data-memory map.
// Region enum plus the address decode function used by the top level.
package hack_memory_map_pkg;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_SCR  = 2'd1,
        REG_KBD  = 2'd2,
        REG_NONE = 2'd3
    } region_e;

    // Address is passed zero-extended to 32 bits so one function serves
    // every ADDR_W. Screen sits directly above RAM at 2^ram_aw.
    function automatic region_e decode(
        input logic [31:0] addr,
        input int          ram_aw,
        input int          scr_aw,
        input logic [31:0] kbd_addr
    );
        logic [31:0] scr_base;
        logic [31:0] scr_end;
        scr_base = 32'd1 << ram_aw;
        scr_end  = scr_base + (32'd1 << scr_aw);
        if (addr < scr_base)
            return REG_RAM;
        else if (addr < scr_end)
            return REG_SCR;
        else if (addr == kbd_addr)
            return REG_KBD;
        else
            return REG_NONE;
    endfunction

endpackage

// File: rtl/hack_memory_map_bank.sv
// mem_map_bank: single-port synchronous RAM, read-first.
// Ports: clk, we/re strobes, addr, wdata, rdata (holds while re is low).
module mem_map_bank #(
    parameter int DATA_W = 16,
    parameter int AW     = 14
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<AW)-1];

    // Non-blocking read of the old word gives read-first on a
    // same-address write; rdata only moves on a real read so the top
    // can hold its output between reads.
    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        if (re)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/hack_memory_map.sv
// Hack data-memory decoder: RAM, screen buffer and keyboard register.
// Ports: CPU side (in, address, load, rd_en, out, out_valid), keyboard
// (key_code, key_strobe, key_pending), screen forward (scr_wr_*), err/err_clr.
module hack_memory_map
    import hack_memory_map_pkg::*;
#(
    parameter int                DATA_W          = 16,
    parameter int                ADDR_W          = 15,
    parameter int                RAM_AW          = 14,
    parameter int                SCR_AW          = 13,
    parameter logic [ADDR_W-1:0] KBD_ADDR        = 15'h6000,
    parameter bit                KBD_CLR_ON_READ = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in,
    input  logic [ADDR_W-1:0] address,
    input  logic              load,
    input  logic              rd_en,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    input  logic [DATA_W-1:0] key_code,
    input  logic              key_strobe,
    output logic              key_pending,
    output logic              scr_wr_valid,
    output logic [SCR_AW-1:0] scr_wr_addr,
    output logic [DATA_W-1:0] scr_wr_data,
    output logic              err,
    input  logic              err_clr
);

    localparam logic [ADDR_W-1:0] SCR_BASE = ADDR_W'(1 << RAM_AW);

    region_e           region;
    region_e           region_q;
    logic [SCR_AW-1:0] scr_off;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] scr_rdata;
    logic [DATA_W-1:0] kbd_q;
    logic [DATA_W-1:0] kbd_rd_q;
    logic              is_ram;
    logic              is_scr;
    logic              is_kbd;
    logic              is_none;
    logic              err_set;

    assign region  = decode(32'(address), RAM_AW, SCR_AW, 32'(KBD_ADDR));
    assign is_ram  = (region == REG_RAM);
    assign is_scr  = (region == REG_SCR);
    assign is_kbd  = (region == REG_KBD);
    assign is_none = (region == REG_NONE);
    assign scr_off = SCR_AW'(address - SCR_BASE);

    mem_map_bank #(
        .DATA_W (DATA_W),
        .AW     (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (load && is_ram),
        .re    (rd_en && is_ram),
        .addr  (address[RAM_AW-1:0]),
        .wdata (in),
        .rdata (ram_rdata)
    );

    mem_map_bank #(
        .DATA_W (DATA_W),
        .AW     (SCR_AW)
    ) u_scr (
        .clk   (clk),
        .we    (load && is_scr),
        .re    (rd_en && is_scr),
        .addr  (scr_off),
        .wdata (in),
        .rdata (scr_rdata)
    );

    // region_q remembers where the last read went; resetting it to
    // REG_NONE makes out read 0 after reset without touching the banks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            region_q  <= REG_NONE;
            out_valid <= 1'b0;
            kbd_rd_q  <= '0;
        end else begin
            out_valid <= rd_en;
            if (rd_en)
                region_q <= region;
            if (rd_en && is_kbd)
                kbd_rd_q <= kbd_q;
        end
    end

    always_comb begin
        out = '0;
        unique case (region_q)
            REG_RAM:  out = ram_rdata;
            REG_SCR:  out = scr_rdata;
            REG_KBD:  out = kbd_rd_q;
            REG_NONE: out = '0;
        endcase
    end

    // Strobe has priority over clear-on-read so a new key is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            kbd_q <= '0;
        else if (key_strobe)
            kbd_q <= key_code;
        else if (KBD_CLR_ON_READ && rd_en && is_kbd)
            kbd_q <= '0;
    end

    assign key_pending = |kbd_q;

    assign err_set = (load && (is_kbd || is_none)) || (rd_en && is_none);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else if (err_set)
            err <= 1'b1;
        else if (err_clr)
            err <= 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scr_wr_valid <= 1'b0;
            scr_wr_addr  <= '0;
            scr_wr_data  <= '0;
        end else begin
            scr_wr_valid <= load && is_scr;
            if (load && is_scr) begin
                scr_wr_addr <= scr_off;
                scr_wr_data <= in;
            end
        end
    end

endmodule

// File: tb/tb_hack_memory_map.sv
// Self-checking bench for hack_memory_map, default and clear-on-read builds.
// Directed steps followed by random traffic against an array-based model.
module tb_hack_memory_map;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] din = '0;
    logic [14:0] address = '0;
    logic        load = 1'b0;
    logic        rd_en = 1'b0;
    logic [15:0] key_code = '0;
    logic        key_strobe = 1'b0;
    logic        err_clr = 1'b0;

    logic [15:0] out_a, out_c;
    logic        vld_a, vld_c;
    logic        kp_a, kp_c;
    logic        sv_a, sv_c;
    logic [12:0] sa_a, sa_c;
    logic [15:0] sd_a, sd_c;
    logic        err_a, err_c;

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] mem_m [0:32767];
    bit          wr_m  [0:32767];
    logic [15:0] kbd_a, kbd_c;
    logic [15:0] eo_a, eo_c;
    bit          out_known;
    bit          e_valid, e_err, e_sv;
    logic [12:0] e_sa;
    logic [15:0] e_sd;

    logic [14:0] pool [0:15];

    always #5 clk = ~clk;

    hack_memory_map dut_a (
        .clk (clk), .rst_n (rst_n), .in (din), .address (address),
        .load (load), .rd_en (rd_en), .out (out_a), .out_valid (vld_a),
        .key_code (key_code), .key_strobe (key_strobe),
        .key_pending (kp_a), .scr_wr_valid (sv_a), .scr_wr_addr (sa_a),
        .scr_wr_data (sd_a), .err (err_a), .err_clr (err_clr)
    );

    hack_memory_map #(.KBD_CLR_ON_READ(1'b1)) dut_c (
        .clk (clk), .rst_n (rst_n), .in (din), .address (address),
        .load (load), .rd_en (rd_en), .out (out_c), .out_valid (vld_c),
        .key_code (key_code), .key_strobe (key_strobe),
        .key_pending (kp_c), .scr_wr_valid (sv_c), .scr_wr_addr (sa_c),
        .scr_wr_data (sd_c), .err (err_c), .err_clr (err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        if (out_known) begin
            chk("out_a", 32'(out_a), 32'(eo_a));
            chk("out_c", 32'(out_c), 32'(eo_c));
        end
        chk("valid_a", 32'(vld_a), 32'(e_valid));
        chk("valid_c", 32'(vld_c), 32'(e_valid));
        chk("err_a", 32'(err_a), 32'(e_err));
        chk("err_c", 32'(err_c), 32'(e_err));
        chk("kpend_a", 32'(kp_a), 32'(kbd_a != 0));
        chk("kpend_c", 32'(kp_c), 32'(kbd_c != 0));
        chk("scr_v_a", 32'(sv_a), 32'(e_sv));
        chk("scr_v_c", 32'(sv_c), 32'(e_sv));
        chk("scr_a_a", 32'(sa_a), 32'(e_sa));
        chk("scr_a_c", 32'(sa_c), 32'(e_sa));
        chk("scr_d_a", 32'(sd_a), 32'(e_sd));
        chk("scr_d_c", 32'(sd_c), 32'(e_sd));
    endtask

    task automatic model_reset();
        eo_a = '0; eo_c = '0; out_known = 1'b1;
        e_valid = 1'b0; e_err = 1'b0; e_sv = 1'b0;
        e_sa = '0; e_sd = '0;
        kbd_a = '0; kbd_c = '0;
    endtask

    task automatic step(input logic [15:0] d, input logic [14:0] a,
                        input bit ld, input bit rd, input bit ks,
                        input logic [15:0] kc, input bit ec);
        bit is_ram, is_scr, is_kbd, is_none;
        @(negedge clk);
        din = d; address = a; load = ld; rd_en = rd;
        key_strobe = ks; key_code = kc; err_clr = ec;
        is_ram  = (a < 15'h4000);
        is_scr  = (a >= 15'h4000) && (a < 15'h6000);
        is_kbd  = (a == 15'h6000);
        is_none = !(is_ram || is_scr || is_kbd);
        if (rd) begin
            if (is_ram || is_scr) begin
                eo_a = mem_m[a]; eo_c = mem_m[a]; out_known = wr_m[a];
            end else if (is_kbd) begin
                eo_a = kbd_a; eo_c = kbd_c; out_known = 1'b1;
            end else begin
                eo_a = '0; eo_c = '0; out_known = 1'b1;
            end
        end
        e_valid = rd;
        if ((ld && (is_kbd || is_none)) || (rd && is_none))
            e_err = 1'b1;
        else if (ec)
            e_err = 1'b0;
        if (ld && (is_ram || is_scr)) begin
            mem_m[a] = d; wr_m[a] = 1'b1;
        end
        e_sv = ld && is_scr;
        if (e_sv) begin
            e_sa = 13'(a - 15'h4000); e_sd = d;
        end
        if (ks) begin
            kbd_a = kc; kbd_c = kc;
        end else if (rd && is_kbd) begin
            kbd_c = '0;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        step(16'h0, 15'h0, 0, 0, 0, 16'h0, 0);
    endtask

    initial begin
        logic [14:0] ra;
        int          sel;
        foreach (wr_m[i]) wr_m[i] = 1'b0;
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        step(16'h1234, 15'h0005, 1, 0, 0, 16'h0, 0);
        step(16'h0000, 15'h0005, 0, 1, 0, 16'h0, 0);
        idle();

        step(16'hFFFF, 15'h4010, 1, 0, 0, 16'h0, 0);
        step(16'h0000, 15'h4010, 0, 1, 0, 16'h0, 0);
        idle();

        step(16'h0, 15'h0, 0, 0, 1, 16'h0041, 0);
        step(16'h0, 15'h6000, 0, 1, 0, 16'h0, 0);
        step(16'h0, 15'h6000, 0, 1, 0, 16'h0, 0);
        step(16'h0, 15'h0, 0, 0, 1, 16'h0042, 0);
        step(16'h0, 15'h6000, 0, 1, 1, 16'h0043, 0);
        step(16'h0, 15'h6000, 0, 1, 0, 16'h0, 0);

        step(16'h0, 15'h6001, 0, 1, 0, 16'h0, 0);
        idle();
        step(16'h0, 15'h0, 0, 0, 0, 16'h0, 1);
        step(16'hBEEF, 15'h6000, 1, 0, 0, 16'h0, 0);
        step(16'h0, 15'h6000, 0, 1, 0, 16'h0, 0);
        step(16'h0, 15'h0, 0, 0, 0, 16'h0, 1);
        step(16'h0, 15'h7FFF, 1, 0, 0, 16'h0, 1);
        step(16'h0, 15'h0, 0, 0, 0, 16'h0, 1);

        step(16'h0007, 15'h0003, 1, 0, 0, 16'h0, 0);
        step(16'h0009, 15'h0003, 1, 1, 0, 16'h0, 0);
        step(16'h0000, 15'h0003, 0, 1, 0, 16'h0, 0);
        step(16'h0, 15'h0, 0, 0, 1, 16'h0, 0);

        step(16'h0, 15'h0, 0, 0, 1, 16'h0055, 0);
        step(16'h0, 15'h6001, 0, 0, 0, 16'h0, 0);
        step(16'h0, 15'h0005, 0, 1, 0, 16'h0, 0);
        @(negedge clk);
        rst_n = 1'b0; load = 1'b0; rd_en = 1'b0;
        key_strobe = 1'b0; err_clr = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        idle();
        step(16'h0, 15'h0005, 0, 1, 0, 16'h0, 0);
        step(16'h0, 15'h4010, 0, 1, 0, 16'h0, 0);

        for (int i = 0; i < 16; i++) begin
            if (i < 8)
                pool[i] = 15'($urandom_range(0, 16'h3FFF));
            else
                pool[i] = 15'($urandom_range(16'h4000, 16'h5FFF));
            step(16'($urandom), pool[i], 1, 0, 0, 16'h0, 0);
        end

        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 7)
                ra = pool[$urandom_range(0, 15)];
            else if (sel < 9)
                ra = 15'h6000;
            else
                ra = 15'($urandom_range(16'h6001, 16'h7FFF));
            step(16'($urandom), ra,
                 $urandom_range(0, 9) < 3,
                 $urandom_range(0, 9) < 5,
                 $urandom_range(0, 9) < 2,
                 ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom),
                 $urandom_range(0, 9) == 0);
        end

        idle();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
